// File: rtl/bist_fail_logger.sv
// Fail-capture log for the SRAM memory BIST.
// Holds up to DEPTH distinct failures in a first-word-fall-through FIFO. Also keeps a
// saturating fail counter, a sticky overflow flag and an IDLE/ARMED/DONE session FSM.
module bist_fail_logger #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned WORD_WIDTH = 4,
    parameter int unsigned DEPTH      = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      arm,
    input  logic                      clear,
    input  logic                      bist_done,
    input  logic                      fail,
    input  logic [ADDR_WIDTH-1:0]     fail_addr,
    input  logic [WORD_WIDTH-1:0]     fail_data,
    input  logic                      log_ready,
    output logic                      log_valid,
    output logic [ADDR_WIDTH-1:0]     log_addr,
    output logic [WORD_WIDTH-1:0]     log_data,
    output logic [$clog2(DEPTH):0]    log_count,
    output logic [15:0]               fail_count,
    output logic                      overflow,
    output logic [1:0]                state,
    output logic                      pass
);

    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned CNT_W   = PTR_W + 1;
    localparam int unsigned ENTRY_W = ADDR_WIDTH + WORD_WIDTH;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StArmed = 2'd1,
        StDone  = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [15:0]            fail_count_q, fail_count_d;
    logic                   overflow_q, overflow_d;
    logic [ADDR_WIDTH-1:0]  last_addr_q, last_addr_d;
    logic                   last_valid_q, last_valid_d;
    logic [ENTRY_W-1:0]     mem_q [DEPTH];

    logic                   capture;
    logic                   dup;
    logic                   push_want;
    logic                   full;
    logic                   push;
    logic                   pop;
    logic                   drop;
    logic [ENTRY_W-1:0]     head;

    // Capture/push/pop qualification; clear overrides everything in its cycle.
    always_comb begin
        capture   = (state_q == StArmed) && fail && !clear;
        dup       = last_valid_q && (fail_addr == last_addr_q);
        push_want = capture && !dup;
        full      = (count_q == CNT_W'(DEPTH));
        // Pop only when an entry was already presented, so an empty FIFO never pops.
        pop       = log_valid && log_ready && !clear;
        // A full FIFO still accepts a push when the head leaves in the same cycle.
        push      = push_want && (!full || pop);
        drop      = push_want && full && !pop;
    end

    // Session state machine: clear wins over arm and bist_done.
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle:  if (arm)       state_d = StArmed;
                StArmed: if (bist_done) state_d = StDone;
                StDone:  state_d = StDone;
                default: state_d = StIdle;
            endcase
        end
    end

    // FIFO pointers and occupancy.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            unique case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Fail counter, overflow flag and duplicate-filter register.
    always_comb begin
        fail_count_d = fail_count_q;
        overflow_d   = overflow_q;
        last_addr_d  = last_addr_q;
        last_valid_d = last_valid_q;
        if (clear) begin
            fail_count_d = '0;
            overflow_d   = 1'b0;
            last_addr_d  = '0;
            last_valid_d = 1'b0;
        end else begin
            if (capture && (fail_count_q != 16'hFFFF)) begin
                fail_count_d = fail_count_q + 16'd1;
            end
            if (drop) begin
                overflow_d = 1'b1;
            end
            // Dropped entries were never pushed, so they do not update the filter.
            if (push) begin
                last_addr_d  = fail_addr;
                last_valid_d = 1'b1;
            end
        end
    end

    // Control and status registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            fail_count_q <= '0;
            overflow_q   <= 1'b0;
            last_addr_q  <= '0;
            last_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            fail_count_q <= fail_count_d;
            overflow_q   <= overflow_d;
            last_addr_q  <= last_addr_d;
            last_valid_q <= last_valid_d;
        end
    end

    // Log storage; contents are don't-care until written, outputs are masked when empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {fail_addr, fail_data};
        end
    end

    // Read port and status outputs.
    always_comb begin
        head       = mem_q[rd_ptr_q];
        log_valid  = (count_q != '0);
        log_addr   = log_valid ? head[ENTRY_W-1:WORD_WIDTH] : '0;
        log_data   = log_valid ? head[WORD_WIDTH-1:0] : '0;
        log_count  = count_q;
        fail_count = fail_count_q;
        overflow   = overflow_q;
        state      = state_q;
        pass       = (state_q == StDone) && (fail_count_q == 16'd0);
    end

endmodule

// File: tb/tb_bist_fail_logger.sv
// Self-checking bench for bist_fail_logger: queue-based reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_bist_fail_logger;

    localparam int AW = 8;
    localparam int WW = 4;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          arm = 1'b0;
    logic          clear = 1'b0;
    logic          bist_done = 1'b0;
    logic          fail = 1'b0;
    logic [AW-1:0] fail_addr = '0;
    logic [WW-1:0] fail_data = '0;
    logic          log_ready = 1'b0;
    logic          log_valid;
    logic [AW-1:0] log_addr;
    logic [WW-1:0] log_data;
    logic [3:0]    log_count;
    logic [15:0]   fail_count;
    logic          overflow;
    logic [1:0]    state;
    logic          pass;

    int checks = 0;
    int errors = 0;

    bist_fail_logger #(
        .ADDR_WIDTH(AW),
        .WORD_WIDTH(WW),
        .DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .arm(arm),
        .clear(clear),
        .bist_done(bist_done),
        .fail(fail),
        .fail_addr(fail_addr),
        .fail_data(fail_data),
        .log_ready(log_ready),
        .log_valid(log_valid),
        .log_addr(log_addr),
        .log_data(log_data),
        .log_count(log_count),
        .fail_count(fail_count),
        .overflow(overflow),
        .state(state),
        .pass(pass)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: log is a queue of {addr,data}; session is 0 idle, 1 armed, 2 done.
    logic [AW+WW-1:0] mq[$];
    int               m_cnt = 0;
    bit               m_ovf = 0;
    int               m_state = 0;
    logic [AW-1:0]    m_last = '0;
    bit               m_lv = 0;
    bit               m_pop;

    task automatic model_step();
        if (!rst) begin
            mq.delete();
            m_cnt = 0; m_ovf = 0; m_state = 0; m_lv = 0;
        end else if (clear) begin
            mq.delete();
            m_cnt = 0; m_ovf = 0; m_state = 0; m_lv = 0;
        end else begin
            m_pop = (mq.size() != 0) && log_ready;
            if (m_pop) void'(mq.pop_front());
            if (m_state == 1 && fail) begin
                if (m_cnt < 65535) m_cnt++;
                if (!(m_lv && fail_addr == m_last)) begin
                    if (mq.size() < DEPTH) begin
                        mq.push_back({fail_addr, fail_data});
                        m_last = fail_addr;
                        m_lv = 1;
                    end else begin
                        m_ovf = 1;
                    end
                end
            end
            if (m_state == 0 && arm) m_state = 1;
            else if (m_state == 1 && bist_done) m_state = 2;
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rst);
        model_step();
    end

    // Compare DUT against model on every falling edge.
    initial forever begin
        @(negedge clk);
        check("m_valid", log_valid, mq.size() != 0);
        check("m_count", log_count, mq.size());
        check("m_fail_count", fail_count, m_cnt);
        check("m_overflow", overflow, m_ovf);
        check("m_state", state, m_state);
        check("m_pass", pass, (m_state == 2) && (m_cnt == 0));
        if (mq.size() != 0) begin
            check("m_head", {log_addr, log_data}, mq[0]);
        end
    end

    // Apply current inputs at the next rising edge, then sample 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fail_at(input logic [AW-1:0] a, input logic [WW-1:0] d);
        fail = 1'b1; fail_addr = a; fail_data = d;
        step();
        fail = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1; step(); clear = 1'b0;
    endtask

    task automatic pulse_arm();
        arm = 1'b1; step(); arm = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #12 rst = 1'b1;
        step();
        check("rst_valid", log_valid, 0);
        check("rst_count", log_count, 0);
        check("rst_state", state, 0);
        check("rst_addr", log_addr, 0);

        // Fails in IDLE are ignored.
        fail = 1'b1; fail_addr = 8'h10;
        repeat (3) step();
        fail = 1'b0;
        check("idle_valid", log_valid, 0);
        check("idle_fcnt", fail_count, 0);
        check("idle_state", state, 0);

        // Basic capture and in-order readout.
        pulse_arm();
        check("arm_state", state, 1);
        fail_at(8'h05, 4'hA);
        check("cap_latency_valid", log_valid, 1);
        check("cap_latency_fcnt", fail_count, 1);
        fail_at(8'h20, 4'h3);
        fail_at(8'hFF, 4'h0);
        bist_done = 1'b1; step(); bist_done = 1'b0;
        check("basic_count", log_count, 3);
        check("basic_state", state, 2);
        check("basic_head0", {log_addr, log_data}, 12'h05A);
        log_ready = 1'b1;
        step();
        check("basic_head1", {log_addr, log_data}, 12'h203);
        step();
        check("basic_head2", {log_addr, log_data}, 12'hFF0);
        step();
        log_ready = 1'b0;
        check("basic_drained", log_count, 0);
        check("basic_fcnt", fail_count, 3);
        check("basic_pass", pass, 0);

        // Duplicate suppression.
        pulse_clear();
        pulse_arm();
        repeat (3) fail_at(8'h40, 4'h1);
        fail_at(8'h41, 4'h2);
        check("dup_count", log_count, 2);
        check("dup_fcnt", fail_count, 4);

        // Overflow, then simultaneous push/pop while full.
        pulse_clear();
        pulse_arm();
        for (int i = 0; i < 10; i++) fail_at(8'h80 + 8'(i), 4'(i));
        check("ovf_count", log_count, 8);
        check("ovf_flag", overflow, 1);
        check("ovf_fcnt", fail_count, 10);
        check("ovf_head", log_addr, 8'h80);
        log_ready = 1'b1;
        fail_at(8'h90, 4'h9);
        log_ready = 1'b0;
        check("pp_count", log_count, 8);
        check("pp_head", log_addr, 8'h81);
        check("pp_fcnt", fail_count, 11);

        // Pass path, clear, and fail coincident with bist_done.
        pulse_clear();
        check("clr_valid", log_valid, 0);
        check("clr_ovf", overflow, 0);
        pulse_arm();
        bist_done = 1'b1; step(); bist_done = 1'b0;
        check("pass_state", state, 2);
        check("pass_high", pass, 1);
        arm = 1'b1; step(); arm = 1'b0;
        check("arm_in_done", state, 2);
        pulse_clear();
        check("clr_state", state, 0);
        check("clr_pass", pass, 0);
        check("clr_fcnt", fail_count, 0);
        // clear beats arm in the same cycle.
        clear = 1'b1; arm = 1'b1; step(); clear = 1'b0; arm = 1'b0;
        check("clr_prio", state, 0);
        pulse_arm();
        fail = 1'b1; fail_addr = 8'h33; fail_data = 4'h7; bist_done = 1'b1;
        step();
        fail = 1'b0; bist_done = 1'b0;
        check("coinc_fcnt", fail_count, 1);
        check("coinc_state", state, 2);
        check("coinc_head", {log_addr, log_data}, 12'h337);

        // Async reset mid-drain with five entries held.
        pulse_clear();
        pulse_arm();
        for (int i = 0; i < 5; i++) fail_at(8'h50 + 8'(i), 4'(i + 1));
        check("pre_rst_count", log_count, 5);
        log_ready = 1'b1;
        #2 rst = 1'b0;
        #1;
        check("arst_valid", log_valid, 0);
        check("arst_count", log_count, 0);
        check("arst_fcnt", fail_count, 0);
        check("arst_state", state, 0);
        check("arst_ovf", overflow, 0);
        check("arst_addr", log_addr, 0);
        check("arst_data", log_data, 0);
        log_ready = 1'b0;
        step();
        #2 rst = 1'b1;
        step();
        check("post_rst_state", state, 0);
        check("post_rst_valid", log_valid, 0);
        repeat (2) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bist_fail_logger.md
# bist_fail_logger

Fail-capture and readout block at the result end of the SRAM memory BIST. Each cycle it samples the BIST `fail` flag with its failing address and observed data word. It stores up to `DEPTH` distinct failures in an internal FIFO and presents them to a tester or host over a valid/ready read port. It also keeps a saturating total-fail counter, an overflow flag, and a session state machine so results survive until explicitly cleared.

## Interface

Parameters:
- `ADDR_WIDTH`, default 8: width of the SRAM address (256 words).
- `WORD_WIDTH`, default 4: width of the SRAM data word.
- `DEPTH`, default 8: number of log entries; must be a power of 2, at least 2.

Ports:
- `clk`, input, 1: the single clock; all state updates on the rising edge.
- `rst`, input, 1: asynchronous active-low reset. Asserting it clears all state immediately; deassertion is synchronous to `clk` upstream.
- `arm`, input, 1: pulse that starts a capture session.
- `clear`, input, 1: synchronous clear of the log, counters and flags; returns the block to IDLE.
- `bist_done`, input, 1: the BIST has finished its march; ends the session.
- `fail`, input, 1: per-cycle compare failure from the BIST.
- `fail_addr`, input, `ADDR_WIDTH`: address associated with `fail`.
- `fail_data`, input, `WORD_WIDTH`: data word read back from the SRAM in that cycle.
- `log_ready`, input, 1: the reader accepts the current entry.
- `log_valid`, output, 1: a log entry is presented.
- `log_addr`, output, `ADDR_WIDTH`: address of the presented entry.
- `log_data`, output, `WORD_WIDTH`: observed data of the presented entry.
- `log_count`, output, `log2(DEPTH)+1`: number of entries currently held.
- `fail_count`, output, 16: total fail cycles in the session, saturating.
- `overflow`, output, 1: sticky; at least one distinct failure was dropped because the log was full.
- `state`, output, 2: 0 IDLE, 1 ARMED, 2 DONE.
- `pass`, output, 1: high in DONE when `fail_count` is 0.

## Operation

- The state machine has three states.
  - IDLE goes to ARMED on `arm`.
  - ARMED goes to DONE on `bist_done`.
  - DONE goes to IDLE on `clear`.
  - `clear` from any state goes to IDLE, empties the FIFO, and zeroes `fail_count` and `overflow`. `clear` has priority over `arm` and `bist_done` in the same cycle.
  - `arm` in ARMED or DONE is ignored.
- Capture happens only in ARMED. `fail` is ignored in IDLE and DONE.
- In ARMED with `fail`=1:
  - `fail_count` increments, saturating at 0xFFFF.
  - The entry {`fail_addr`, `fail_data`} is pushed unless it is a duplicate.
  - A duplicate is an entry whose `fail_addr` equals the address of the most recently pushed entry in this session. The "last pushed" register is invalidated by `clear` and reset.
  - If the push is wanted but the FIFO is full and not popping in the same cycle, the entry is dropped and `overflow` sets.
- `fail` and `bist_done` in the same cycle: the fail is captured, then the state goes to DONE.
- Read port, first-word-fall-through:
  - `log_valid` = (`log_count` ≠ 0).
  - `log_addr` and `log_data` show the head entry.
  - A pop happens on a rising edge with `log_valid` and `log_ready` both high.
  - Reads are allowed in every state, so the log can be drained during ARMED.
- Push and pop in the same cycle:
  - Both take effect and `log_count` is unchanged.
  - This holds when full, so no overflow occurs.
  - This holds when empty only if the pop is qualified by the prior `log_valid`; an empty FIFO never pops.
- Pointers are `log2(DEPTH)` bits and wrap modulo `DEPTH`. `log_count` ranges over 0..DEPTH.
- `pass` = (`state`==DONE) && (`fail_count`==0). `overflow` does not affect `pass`.

## Timing

- Reset values:
  - `state`=IDLE.
  - `log_valid`=0, `log_count`=0, `fail_count`=0, `overflow`=0, `pass`=0.
  - `log_addr` and `log_data` are 0.
  - Last-pushed register is invalid.
- Capture latency: a `fail` sampled at edge N shows `log_valid`=1 and `fail_count` incremented after edge N, so it is visible in cycle N+1.
- Pop: the head advances after the accepting edge, and the next entry is visible in the following cycle.
- `state` changes one edge after `arm`, `bist_done` or `clear`. `pass` follows combinationally from the registered state.
- Reset mid-session: all outputs return to reset values asynchronously, and log contents are lost.
- `clear` is synchronous. The cycle after it, `log_valid`=0.

## Test plan

- Reset and idle: release `rst`, drive `fail`=1 with `fail_addr`=0x10 in IDLE for 3 cycles -> `log_valid`=0, `fail_count`=0, `state`=0.
- Basic capture and readout:
  - Stimulus: `arm`, then fails at 0x05/0xA, 0x20/0x3 and 0xFF/0x0, then `bist_done`, then drain with `log_ready`=1.
  - Required response: entries appear in that order, then `log_count`=0, `fail_count`=3, `state`=2, `pass`=0.
- Duplicate suppression: three consecutive fails at 0x40, then one at 0x41 -> `log_count`=2, `fail_count`=4.
- Overflow and simultaneous push/pop (`DEPTH`=8):
  - Ten distinct fails with `log_ready`=0 -> `log_count`=8, `overflow`=1, `fail_count`=10.
  - Then one more fail with `log_ready`=1 in the same cycle -> `log_count` stays 8, and the head advances.
- Pass path and clear:
  - `arm` then `bist_done` with no fails -> `pass`=1 in DONE.
  - `clear` -> `state`=0, `pass`=0, counters zero.
  - `fail` coincident with `bist_done` -> captured, `fail_count`=1.
- Async reset mid-drain: assert `rst` low between clock edges with `log_count`=5 -> all outputs reach reset values before the next edge.
